// File: rtl/fht_io_ctrl.sv
// fht_io_ctrl: streams N = 2^(A_BIT+2) samples into the FHT input banks, pulses oSTART, waits on iRDY,
// then streams results out through a 2-entry skid FIFO. Define FHT_IO_BITREV_EN for bit-reversed load addressing.
module fht_io_ctrl #(
  parameter int A_BIT = 8,
  parameter int D_BIT = 16
) (
  input  logic             iCLK,
  input  logic             iRESET,
  input  logic [D_BIT-1:0] iDATA,
  input  logic             iVALID,
  output logic             oREADY,
  output logic [D_BIT-1:0] oDATA,
  output logic             oVALID,
  input  logic             iREADY,
  output logic             oLAST,
  output logic [A_BIT-1:0] oADDR_WR,
  output logic [D_BIT-1:0] oDATA_WR,
  output logic [3:0]       oWE,
  output logic [A_BIT-1:0] oADDR_RD,
  output logic [3:0]       oRE,
  input  logic [D_BIT-1:0] iDATA_RD_0,
  input  logic [D_BIT-1:0] iDATA_RD_1,
  input  logic [D_BIT-1:0] iDATA_RD_2,
  input  logic [D_BIT-1:0] iDATA_RD_3,
  output logic             oSTART,
  input  logic             iRDY,
  output logic             oBUSY
);
  localparam int CW = A_BIT + 2;
  localparam logic [CW-1:0] LAST_IDX = '1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_RUN, S_UNLOAD} state_t;

  state_t           state_q;
  logic [CW-1:0]    wr_cnt_q;
  logic [CW-1:0]    rd_cnt_q;
  logic             rd_done_q;
  logic             seen_low_q;
  logic             start_q;
  logic [3:0]       we_q;
  logic [A_BIT-1:0] waddr_q;
  logic [D_BIT-1:0] wdata_q;
  logic             dv_q;
  logic             dlast_q;
  logic [1:0]       dbank_q;
  logic [D_BIT-1:0] f_dat0_q;
  logic [D_BIT-1:0] f_dat1_q;
  logic [1:0]       f_last_q;
  logic [1:0]       f_occ_q;

  function automatic logic [CW-1:0] load_index(input logic [CW-1:0] k);
    logic [CW-1:0] r;
`ifdef FHT_IO_BITREV_EN
    for (int b = 0; b < CW; b++) r[b] = k[CW-1-b];
`else
    r = k;
`endif
    return r;
  endfunction

  logic [CW-1:0]    wr_idx;
  logic             beat;
  logic             pop;
  logic             push;
  logic             issue;
  logic [2:0]       credit;
  logic [D_BIT-1:0] rd_dat;

  assign wr_idx = load_index(wr_cnt_q);
  assign beat   = (state_q == S_LOAD) & iVALID;
  assign pop    = oVALID & iREADY;
  assign push   = dv_q;
  // Slots owed to the FIFO: stored entries plus the read whose data lands this cycle, less what leaves now.
  assign credit = {1'b0, f_occ_q} + {2'b00, dv_q} - {2'b00, pop};
  assign issue  = (state_q == S_UNLOAD) & ~rd_done_q & (credit < 3'd2);

  always_comb begin
    rd_dat = iDATA_RD_0;
    case (dbank_q)
      2'd1:    rd_dat = iDATA_RD_1;
      2'd2:    rd_dat = iDATA_RD_2;
      2'd3:    rd_dat = iDATA_RD_3;
      default: rd_dat = iDATA_RD_0;
    endcase
  end

  assign oREADY   = (state_q == S_LOAD);
  assign oBUSY    = (state_q != S_IDLE);
  assign oSTART   = start_q;
  assign oWE      = we_q;
  assign oADDR_WR = waddr_q;
  assign oDATA_WR = wdata_q;
  assign oADDR_RD = rd_cnt_q[CW-1:2];
  assign oRE      = issue ? (4'b0001 << rd_cnt_q[1:0]) : 4'b0000;
  assign oVALID   = (f_occ_q != 2'd0);
  assign oDATA    = f_dat0_q;
  assign oLAST    = oVALID & f_last_q[0];

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q    <= S_IDLE;
      wr_cnt_q   <= '0;
      rd_cnt_q   <= '0;
      rd_done_q  <= 1'b0;
      seen_low_q <= 1'b0;
      start_q    <= 1'b0;
      we_q       <= 4'b0000;
      waddr_q    <= '0;
      wdata_q    <= '0;
      dv_q       <= 1'b0;
      dlast_q    <= 1'b0;
      dbank_q    <= 2'd0;
    end else begin
      we_q    <= 4'b0000;
      start_q <= 1'b0;
      dv_q    <= issue;
      dbank_q <= rd_cnt_q[1:0];
      dlast_q <= (rd_cnt_q == LAST_IDX);
      case (state_q)
        S_IDLE: begin
          wr_cnt_q   <= '0;
          rd_cnt_q   <= '0;
          rd_done_q  <= 1'b0;
          seen_low_q <= 1'b0;
          if (iVALID) state_q <= S_LOAD;
        end
        S_LOAD: begin
          if (beat) begin
            we_q    <= 4'b0001 << wr_idx[1:0];
            waddr_q <= wr_idx[CW-1:2];
            wdata_q <= iDATA;
            if (wr_cnt_q == LAST_IDX) state_q <= S_KICK;
            else                      wr_cnt_q <= wr_cnt_q + 1'b1;
          end
        end
        S_KICK: begin
          start_q <= 1'b1;
          state_q <= S_RUN;
        end
        S_RUN: begin
          // A stale high iRDY left over from the previous transform must not count as done.
          if (!iRDY)           seen_low_q <= 1'b1;
          else if (seen_low_q) state_q    <= S_UNLOAD;
        end
        S_UNLOAD: begin
          if (issue) begin
            if (rd_cnt_q == LAST_IDX) rd_done_q <= 1'b1;
            else                      rd_cnt_q  <= rd_cnt_q + 1'b1;
          end
          if (pop && f_last_q[0]) begin
            state_q   <= S_IDLE;
            rd_cnt_q  <= '0;
            rd_done_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      f_occ_q  <= 2'd0;
      f_dat0_q <= '0;
      f_dat1_q <= '0;
      f_last_q <= 2'b00;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (f_occ_q == 2'd0) begin
            f_dat0_q    <= rd_dat;
            f_last_q[0] <= dlast_q;
          end else begin
            f_dat1_q    <= rd_dat;
            f_last_q[1] <= dlast_q;
          end
          f_occ_q <= f_occ_q + 2'd1;
        end
        2'b01: begin
          f_dat0_q    <= f_dat1_q;
          f_last_q[0] <= f_last_q[1];
          f_occ_q     <= f_occ_q - 2'd1;
        end
        2'b11: begin
          if (f_occ_q == 2'd1) begin
            f_dat0_q    <= rd_dat;
            f_last_q[0] <= dlast_q;
          end else begin
            f_dat0_q    <= f_dat1_q;
            f_last_q[0] <= f_last_q[1];
            f_dat1_q    <= rd_dat;
            f_last_q[1] <= dlast_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fht_io_ctrl.sv
// Bench for fht_io_ctrl at A_BIT=2 (16 points): load mapping, start timing, RUN handshake, unload order and stalls, reset abort.
module tb_fht_io_ctrl;
  localparam int AB = 2;
  localparam int DB = 16;

  logic          clk;
  logic          iRESET, iVALID, oREADY, oVALID, iREADY, oLAST, oSTART, iRDY, oBUSY;
  logic [DB-1:0] iDATA, oDATA, oDATA_WR;
  logic [AB-1:0] oADDR_WR, oADDR_RD;
  logic [3:0]    oWE, oRE;
  logic [DB-1:0] rd_q [4];
  logic [DB-1:0] res  [4][4];

  fht_io_ctrl #(.A_BIT(AB), .D_BIT(DB)) dut (
    .iCLK(clk), .iRESET(iRESET),
    .iDATA(iDATA), .iVALID(iVALID), .oREADY(oREADY),
    .oDATA(oDATA), .oVALID(oVALID), .iREADY(iREADY), .oLAST(oLAST),
    .oADDR_WR(oADDR_WR), .oDATA_WR(oDATA_WR), .oWE(oWE),
    .oADDR_RD(oADDR_RD), .oRE(oRE),
    .iDATA_RD_0(rd_q[0]), .iDATA_RD_1(rd_q[1]), .iDATA_RD_2(rd_q[2]), .iDATA_RD_3(rd_q[3]),
    .oSTART(oSTART), .iRDY(iRDY), .oBUSY(oBUSY)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Result banks: synchronous read, data one cycle after oRE.
  always @(posedge clk)
    for (int b = 0; b < 4; b++)
      if (oRE[b]) rd_q[b] <= res[b][oADDR_RD];

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Spec-level model state
  int          beats, pend_k, start_exp, act_start, beat15_cyc, rise_cyc, rd_idx, exp_out;
  int          first_re, first_pop, last_pop;
  bit          wr_pend, seen_low, hold, post_reset;
  logic [3:0]  pend_idx;
  logic [15:0] held, res_base;
  logic [3:0]  obs_we   [16];
  logic [1:0]  obs_addr [16];

  function automatic logic [3:0] map_idx(input int k);
    logic [3:0] kk;
    kk = k[3:0];
`ifdef FHT_IO_BITREV_EN
    return {kk[0], kk[1], kk[2], kk[3]};
`else
    return kk;
`endif
  endfunction

  task automatic model_clear();
    beats = 0; pend_k = 0; start_exp = -1; act_start = -1; beat15_cyc = -1;
    rise_cyc = -1; rd_idx = 0; exp_out = 0; first_re = -1; first_pop = -1; last_pop = -1;
    wr_pend = 0; seen_low = 0; hold = 0; held = '0; pend_idx = '0;
  endtask

  task automatic preload(input logic [15:0] base);
    res_base = base;
    for (int j = 0; j < 16; j++) res[j % 4][j / 4] = base + 16'(j);
  endtask

  always @(negedge clk) begin
    bit ok;
    if (iRESET) begin
      model_clear();
      post_reset = 1;
    end else begin
      if (post_reset) begin
        chk("rst_ctrl", {oREADY, oVALID, oLAST, oWE, oRE, oSTART, oBUSY}, 0);
        chk("rst_bus", {oADDR_WR, oADDR_RD, oDATA_WR}, 0);
        chk("rst_odata", oDATA, 0);
        post_reset = 0;
      end
      // load side: every accepted beat appears as one write in the next cycle
      chk("oWE", oWE, wr_pend ? (4'b0001 << pend_idx[1:0]) : 4'b0000);
      if (wr_pend) begin
        chk("oADDR_WR", oADDR_WR, pend_idx[3:2]);
        chk("oDATA_WR", oDATA_WR, pend_k);
        obs_we[pend_k]   = oWE;
        obs_addr[pend_k] = oADDR_WR;
      end
      wr_pend = 0;
      if (beats == 16) chk("oREADY_after_load", oREADY, 0);
      if (iVALID && oREADY) begin
        pend_k   = beats;
        pend_idx = map_idx(beats);
        wr_pend  = 1;
        beats++;
        if (beats == 16) begin
          beat15_cyc = cyc;
          start_exp  = cyc + 2;
        end
      end
      chk("oSTART", oSTART, cyc == start_exp);
      if (oSTART && act_start < 0) act_start = cyc;
      // RUN: need a low then a high on iRDY, counted from the start pulse
      if (start_exp >= 0 && cyc >= start_exp && rise_cyc < 0) begin
        if (!iRDY)         seen_low = 1;
        else if (seen_low) rise_cyc = cyc;
      end
      ok = (rise_cyc >= 0) && (cyc > rise_cyc);
      if (!ok) chk("oRE_early", oRE, 0);
      else if (oRE != 4'b0000) begin
        chk("oRE", oRE, 4'b0001 << rd_idx[1:0]);
        chk("oADDR_RD", oADDR_RD, rd_idx[3:2]);
        chk("rd_in_range", rd_idx < 16, 1);
        if (first_re < 0) first_re = cyc;
        rd_idx++;
      end
      if (last_pop >= 0 && cyc == last_pop + 1) begin
        chk("oBUSY_end", oBUSY, 0);
        chk("oVALID_end", oVALID, 0);
      end else if (beats > 0 && last_pop < 0) chk("oBUSY", oBUSY, 1);
      // unload side: natural order, held stable under stall
      if (!oVALID) begin
        chk("oLAST_idle", oLAST, 0);
        if (hold) chk("oVALID_hold", oVALID, 1);
        hold = 0;
      end else begin
        if (!ok) chk("oVALID_early", oVALID, 0);
        if (hold) chk("oDATA_hold", oDATA, held);
        if (iREADY) begin
          chk("oDATA", oDATA, res_base + 16'(exp_out));
          chk("oLAST", oLAST, exp_out == 15);
          if (first_pop < 0) first_pop = cyc;
          if (exp_out == 15) last_pop = cyc;
          exp_out++;
          hold = 0;
        end else begin
          held = oDATA;
          hold = 1;
        end
      end
    end
  end

  task automatic do_load(input int abort_at, input bit gaps);
    int  k, g;
    bit  acc;
    k = 0; g = 0;
    @(posedge clk); #1;
    iVALID = 1; iDATA = '0;
    while (k < 16 && g < 200) begin
      if (k == abort_at && oREADY) begin
        iRESET = 1;
        @(posedge clk); #1;
        iRESET = 0; iVALID = 0;
        return;
      end
      @(negedge clk);
      acc = iVALID && oREADY;
      @(posedge clk); #1;
      g++;
      if (acc) k++;
      iDATA  = k[15:0];
      iVALID = (k < 16) && !(gaps && (g % 3 == 1));
    end
    iVALID = 0;
    chk("load_done", k, 16);
  endtask

  task automatic wait_start();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!oSTART && n < 100);
    chk("start_seen", oSTART, 1);
  endtask

  task automatic run_ctrl(input int hi, input int lo);
    repeat (hi) @(posedge clk);
    #1 iRDY = 0;
    repeat (lo) @(posedge clk);
    #1 iRDY = 1;
  endtask

  task automatic unload(input bit toggle);
    int n;
    n = 0;
    while (last_pop < 0 && n < 400) begin
      @(posedge clk); #1;
      iREADY = toggle ? ((n % 4 == 0) || (n % 4 == 3)) : 1'b1;
      n++;
    end
    iREADY = 1;
    chk("unload_done", last_pop >= 0, 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    iRESET = 1; iVALID = 0; iDATA = '0; iREADY = 1; iRDY = 1;
    post_reset = 0;
    for (int b = 0; b < 4; b++) rd_q[b] = '0;
    model_clear();
    preload(16'h0000);
    repeat (3) @(posedge clk);
    #1 iRESET = 0;
    repeat (2) @(posedge clk);
    #1;

    // A: contiguous load, long RUN, free-flowing unload
    model_clear();
    do_load(-1, 0);
    wait_start();
    run_ctrl(5, 20);
    unload(0);
    chk("start_latency", act_start - beat15_cyc, 2);
`ifdef FHT_IO_BITREV_EN
    chk("k1_we", obs_we[1], 4'b0001);
    chk("k1_addr", obs_addr[1], 2);
    chk("k3_we", obs_we[3], 4'b0001);
    chk("k3_addr", obs_addr[3], 3);
    chk("k6_we", obs_we[6], 4'b0100);
    chk("k6_addr", obs_addr[6], 1);
`else
    chk("k6_we", obs_we[6], 4'b0100);
    chk("k6_addr", obs_addr[6], 1);
    chk("k1_we", obs_we[1], 4'b0010);
    chk("k1_addr", obs_addr[1], 0);
    chk("k3_we", obs_we[3], 4'b1000);
    chk("k3_addr", obs_addr[3], 0);
`endif
    chk("no_early_re", first_re > rise_cyc, 1);
    chk("re_after_rise", first_re <= rise_cyc + 2, 1);
    chk("consecutive_out", last_pop - first_pop, 15);
    chk("count_A", exp_out, 16);

    // B: gappy load, stalled unload
    model_clear();
    preload(16'h5A00);
    do_load(-1, 1);
    wait_start();
    run_ctrl(1, 3);
    unload(1);
    chk("count_B", exp_out, 16);
    chk("stall_span", last_pop - first_pop > 15, 1);

    // C: reset during beat 7, then a fresh full pass
    model_clear();
    preload(16'h0C30);
    do_load(7, 0);
    @(posedge clk); #1;
    chk("abort_idle", {oBUSY, oREADY, oVALID}, 0);
    model_clear();
    do_load(-1, 0);
    wait_start();
    run_ctrl(1, 3);
    unload(0);
`ifdef FHT_IO_BITREV_EN
    chk("k7_we", obs_we[7], 4'b0100);
    chk("k7_addr", obs_addr[7], 3);
`else
    chk("k7_we", obs_we[7], 4'b1000);
    chk("k7_addr", obs_addr[7], 1);
`endif
    chk("count_C", exp_out, 16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
